// File: rtl/fft_sample_buffer.sv
// Ping-pong frame buffer between the SPI sample receiver and the FFT core.
// Define FFT_BITREV_EN to store each frame in bit-reversed address order.
module fft_sample_buffer #(
  parameter int unsigned N     = 256,
  parameter int unsigned LOG2N = 8,
  parameter int unsigned W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     sample_in,
  input  logic             sample_valid,
  input  logic             fft_rd_en,
  input  logic [LOG2N-1:0] fft_rd_addr,
  output logic [W-1:0]     fft_rd_data,
  output logic             frame_ready,
  input  logic             frame_release,
  output logic             overflow,
  output logic [LOG2N:0]   fill_count
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  localparam logic [LOG2N:0] PtrLast = (LOG2N+1)'(N - 1);

  state_e           state_q;
  logic             wr_bank_q;
  logic             rd_owned_q;
  logic             swap_q;
  logic             frame_ready_q;
  logic             overflow_q;
  logic [LOG2N:0]   wr_ptr_q;
  logic [W-1:0]     rd_data_q;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_en;
  logic             last_wr;
  logic             do_swap;

  logic [W-1:0] mem [2*N];

`ifdef FFT_BITREV_EN
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      wr_addr[i] = wr_ptr_q[int'(LOG2N) - 1 - i];
    end
  end
`else
  assign wr_addr = wr_ptr_q[LOG2N-1:0];
`endif

  assign wr_en   = reset_n && sample_valid && (state_q == StFill);
  assign last_wr = wr_en && (wr_ptr_q == PtrLast);
  // A release arriving with the last sample frees the read bank in time to swap.
  assign do_swap = (last_wr && (!rd_owned_q || frame_release)) ||
                   ((state_q == StHold) && frame_release);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_addr}] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StFill;
      wr_bank_q     <= 1'b0;
      rd_owned_q    <= 1'b0;
      swap_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_data_q     <= '0;
    end else begin
      swap_q        <= do_swap;
      frame_ready_q <= swap_q;
      if (fft_rd_en) begin
        rd_data_q <= mem[{~wr_bank_q, fft_rd_addr}];
      end
      if ((state_q == StHold) && sample_valid) begin
        overflow_q <= 1'b1;
      end
      if (do_swap) begin
        state_q    <= StFill;
        wr_bank_q  <= ~wr_bank_q;
        wr_ptr_q   <= '0;
        rd_owned_q <= 1'b1;
      end else begin
        if (frame_release) begin
          rd_owned_q <= 1'b0;
        end
        if (last_wr) begin
          state_q <= StHold;
        end
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
    end
  end

  assign fft_rd_data = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign overflow    = overflow_q;
  assign fill_count  = wr_ptr_q;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Self-checking bench for fft_sample_buffer: frame-level model plus directed literal checks.
// Honours FFT_BITREV_EN for the expected storage order.
module tb_fft_sample_buffer;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        fft_rd_en = 1'b0;
  logic [7:0]  fft_rd_addr = '0;
  logic [15:0] fft_rd_data;
  logic        frame_ready;
  logic        frame_release = 1'b0;
  logic        overflow;
  logic [8:0]  fill_count;

  int checks = 0;
  int errors = 0;

  fft_sample_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft_rd_en    (fft_rd_en),
    .fft_rd_addr  (fft_rd_addr),
    .fft_rd_data  (fft_rd_data),
    .frame_ready  (frame_ready),
    .frame_release(frame_release),
    .overflow     (overflow),
    .fill_count   (fill_count)
  );

  always #5 clk = ~clk;

  // Frame-level model: two banks, a count of samples in the write bank and an ownership flag.
  int m_mem   [2][N];
  bit m_known [2][N];
  int m_bank, m_count, m_pend, m_ready, m_rd;
  bit m_owned, m_ovf, m_rd_known, mon_en;

  function automatic int store_addr(int k);
`ifdef FFT_BITREV_EN
    int r = 0;
    for (int i = 0; i < 8; i++) r |= ((k >> i) & 1) << (7 - i);
    return r;
`else
    return k;
`endif
  endfunction

  initial begin
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_known[b][i] = 1'b0;
    m_bank = 0; m_count = 0; m_pend = 0; m_ready = 0; m_rd = 0;
    m_owned = 0; m_ovf = 0; m_rd_known = 0; mon_en = 0;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_bank = 0; m_count = 0; m_pend = 0; m_ready = 0; m_rd = 0;
      m_owned = 0; m_ovf = 0; m_rd_known = 1;
    end else begin
      m_ready = m_pend;
      m_pend  = 0;
      if (fft_rd_en) begin
        m_rd       = m_mem[1 - m_bank][fft_rd_addr];
        m_rd_known = m_known[1 - m_bank][fft_rd_addr];
      end
      if (sample_valid) begin
        if (m_count == N) begin
          m_ovf = 1;
        end else begin
          m_mem[m_bank][store_addr(m_count)]   = int'(sample_in);
          m_known[m_bank][store_addr(m_count)] = 1'b1;
          m_count++;
        end
      end
      if (m_count == N && (!m_owned || frame_release)) begin
        m_bank  = 1 - m_bank;
        m_count = 0;
        m_owned = 1;
        m_pend  = 1;
      end else if (frame_release) begin
        m_owned = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("model fill_count", int'(fill_count), m_count);
      chk("model overflow", int'(overflow), int'(m_ovf));
      chk("model frame_ready", int'(frame_ready), m_ready);
      if (m_rd_known) chk("model fft_rd_data", int'(fft_rd_data), m_rd);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_frame(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      sample_in    = 16'(base + i);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic rd(input int addr);
    fft_rd_en   = 1'b1;
    fft_rd_addr = 8'(addr);
    tick();
    fft_rd_en   = 1'b0;
  endtask

  int rd_addrs [5] = '{0, 1, 5, 128, 255};
`ifdef FFT_BITREV_EN
  int rd_exp   [5] = '{0, 128, 160, 1, 255};
  localparam int T2Exp = 1192, T4Exp1 = 2384, T5Exp = 3064;
`else
  int rd_exp   [5] = '{0, 1, 5, 128, 255};
  localparam int T2Exp = 1003, T4Exp1 = 2257, T5Exp = 3002;
`endif

  int ready_cnt, rel_cd;

  initial begin
    // 1: reset, one full frame, read back
    tick();
    reset_n = 1'b0;
    tick();
    chk("reset fill_count", int'(fill_count), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset frame_ready", int'(frame_ready), 0);
    chk("reset fft_rd_data", int'(fft_rd_data), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    send_frame(0, N);
    chk("t1 fill after swap", int'(fill_count), 0);
    chk("t1 ready +1", int'(frame_ready), 0);
    tick();
    chk("t1 ready +2", int'(frame_ready), 1);
    tick();
    chk("t1 ready +3", int'(frame_ready), 0);
    for (int j = 0; j < 5; j++) begin
      rd(rd_addrs[j]);
      chk("t1 read", int'(fft_rd_data), rd_exp[j]);
    end

    // 2: second frame while owned, overflow, then release
    send_frame(1000, N);
    chk("t2 fill full", int'(fill_count), 256);
    chk("t2 no ready", int'(frame_ready), 0);
    chk("t2 ovf before", int'(overflow), 0);
    send_frame(1256, 1);
    chk("t2 ovf after", int'(overflow), 1);
    chk("t2 fill held", int'(fill_count), 256);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    chk("t2 fill after release", int'(fill_count), 0);
    tick();
    chk("t2 ready", int'(frame_ready), 1);
    rd(3);
    chk("t2 read", int'(fft_rd_data), T2Exp);

    // 3: release coincides with the last strobe
    do_reset();
    send_frame(0, N);
    tick();
    tick();
    send_frame(500, N - 1);
    sample_in     = 16'd755;
    sample_valid  = 1'b1;
    frame_release = 1'b1;
    tick();
    sample_valid  = 1'b0;
    frame_release = 1'b0;
    chk("t3 fill", int'(fill_count), 0);
    tick();
    chk("t3 ready", int'(frame_ready), 1);
    chk("t3 ovf", int'(overflow), 0);

    // 4: continuous strobes, release 10 cycles after each frame_ready
    do_reset();
    ready_cnt = 0;
    rel_cd    = 0;
    for (int i = 0; i < 600; i++) begin
      sample_in     = 16'(2000 + i);
      sample_valid  = 1'b1;
      frame_release = (rel_cd == 1);
      tick();
      if (rel_cd > 0) rel_cd--;
      if (frame_ready) begin
        ready_cnt++;
        rel_cd = 10;
      end
    end
    sample_valid  = 1'b0;
    frame_release = 1'b0;
    chk("t4 ready count", ready_cnt, 2);
    chk("t4 ovf", int'(overflow), 0);
    chk("t4 fill", int'(fill_count), 88);
    rd(0);
    chk("t4 read 0", int'(fft_rd_data), 2256);
    rd(1);
    chk("t4 read 1", int'(fft_rd_data), T4Exp1);
    rd(255);
    chk("t4 read 255", int'(fft_rd_data), 2511);

    // 5: reset mid-frame while a frame is owned
    do_reset();
    send_frame(0, N);
    send_frame(100, 100);
    chk("t5 fill pre", int'(fill_count), 100);
    do_reset();
    chk("t5 fill post", int'(fill_count), 0);
    send_frame(3000, N);
    tick();
    chk("t5 ready", int'(frame_ready), 1);
    rd(0);
    chk("t5 read 0", int'(fft_rd_data), 3000);
    rd(2);
    chk("t5 read 2", int'(fft_rd_data), T5Exp);

    // 6: release with nothing owned; idle reads hold data
    frame_release = 1'b1;
    tick();
    tick();
    frame_release = 1'b0;
    fft_rd_addr   = 8'd77;
    tick();
    tick();
    chk("t6 fill", int'(fill_count), 0);
    chk("t6 ready", int'(frame_ready), 0);
    chk("t6 data hold", int'(fft_rd_data), T5Exp);
    send_frame(4000, N);
    tick();
    chk("t6 swap when free", int'(frame_ready), 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
